control_unit: RTL and testbench

- Main control for the single-cycle 32-bit ARM-subset processor.
- Decodes instruction fields Op/Funct/Rd into datapath controls.
- Evaluates the instruction's condition field against an internal NZCV flags register, gating all architectural writes.
- Sits between instruction memory and the register file/ALU/data memory datapath.

---
 rtl/control_pkg.sv | 58 +++++
 rtl/cond_logic.sv | 64 ++++++
 rtl/control_unit.sv | 123 ++++++++++++
 tb/tb_control_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the ARM-subset main control: opcode classes, DP commands,
// ALU operations, condition codes and the extend/register-source selects.
package control_pkg;

   typedef enum logic [1:0] {
      OP_DP  = 2'b00,
      OP_MEM = 2'b01,
      OP_BR  = 2'b10,
      OP_NONE = 2'b11
   } op_e;

   typedef enum logic [3:0] {
      CMD_AND = 4'b0000,
      CMD_EOR = 4'b0001,
      CMD_SUB = 4'b0010,
      CMD_ADD = 4'b0100,
      CMD_CMP = 4'b1010,
      CMD_ORR = 4'b1100,
      CMD_MOV = 4'b1101
   } cmd_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_ORR = 3'b011,
      ALU_EOR = 3'b100,
      ALU_MOV = 3'b101
   } alu_e;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_e;

   localparam logic [1:0] IMM_8  = 2'b00;
   localparam logic [1:0] IMM_12 = 2'b01;
   localparam logic [1:0] IMM_24 = 2'b10;

   localparam logic [1:0] REGSRC_DP  = 2'b00;
   localparam logic [1:0] REGSRC_BR  = 2'b01;
   localparam logic [1:0] REGSRC_STR = 2'b10;

endpackage

// File: rtl/cond_logic.sv
// NZCV flags register, condition evaluation and gating of architectural writes.
// Flags reflect the last flag-setting instruction whose condition passed.
module cond_logic
   import control_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       MemWrite
);

   logic [1:0] flags_nz;
   logic [1:0] flags_cv;
   logic       n, z, c, v;
   logic       cond_ex;

   assign {n, z} = flags_nz;
   assign {c, v} = flags_cv;

   always_comb begin
      cond_ex = 1'b0;
      case (Cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = ~z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = ~c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = ~n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = ~v;
         COND_HI: cond_ex = c & ~z;
         COND_LS: cond_ex = ~c | z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = ~z & (n == v);
         COND_LE: cond_ex = z | (n != v);
         COND_AL: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // NZ and CV halves are written independently so logical ops keep C/V.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_nz <= 2'b00;
         flags_cv <= 2'b00;
      end else begin
         if (FlagW[1] & cond_ex) flags_nz <= ALUFlags[3:2];
         if (FlagW[0] & cond_ex) flags_cv <= ALUFlags[1:0];
      end
   end

   assign PCSrc    = PCS  & cond_ex;
   assign RegWrite = RegW & cond_ex;
   assign MemWrite = MemW & cond_ex;

endmodule

// File: rtl/control_unit.sv
// Main decoder for the single-cycle ARM-subset core; conditional gating lives in cond_logic.
// Optional macro CU_ILLEGAL_DETECT_EN adds the IllegalOp output.
module control_unit
   import control_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   output logic [1:0] FlagW,
   output logic       PCS,
   output logic       RegW,
   output logic       MemW,
   output logic       MemtoReg,
   output logic       ALUSrc,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic [2:0] ALUControl,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       MemWrite
`ifdef CU_ILLEGAL_DETECT_EN
   ,
   output logic       IllegalOp
`endif
);

   logic branch;
   logic is_dp;
   logic is_arith;
   logic cmd_undef;

   always_comb begin
      FlagW      = 2'b00;
      RegW       = 1'b0;
      MemW       = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrc     = 1'b0;
      ImmSrc     = IMM_8;
      RegSrc     = REGSRC_DP;
      ALUControl = ALU_ADD;
      branch     = 1'b0;
      is_dp      = 1'b0;
      is_arith   = 1'b0;
      cmd_undef  = 1'b0;

      case (Op)
         OP_DP: begin
            is_dp  = 1'b1;
            RegW   = 1'b1;
            ALUSrc = Funct[5];
         end
         OP_MEM: begin
            ImmSrc = IMM_12;
            ALUSrc = 1'b1;
            if (Funct[0]) begin
               MemtoReg = 1'b1;
               RegW     = 1'b1;
            end else begin
               RegSrc = REGSRC_STR;
               MemW   = 1'b1;
            end
         end
         OP_BR: begin
            RegSrc = REGSRC_BR;
            ImmSrc = IMM_24;
            ALUSrc = 1'b1;
            branch = 1'b1;
         end
         default: ;
      endcase

      if (is_dp) begin
         case (Funct[4:1])
            CMD_ADD: begin ALUControl = ALU_ADD; is_arith = 1'b1; end
            CMD_SUB: begin ALUControl = ALU_SUB; is_arith = 1'b1; end
            CMD_AND: ALUControl = ALU_AND;
            CMD_ORR: ALUControl = ALU_ORR;
            CMD_EOR: ALUControl = ALU_EOR;
            CMD_MOV: ALUControl = ALU_MOV;
            // CMP only sets flags, so the register write is dropped.
            CMD_CMP: begin
               ALUControl = ALU_SUB;
               is_arith   = 1'b1;
               RegW       = 1'b0;
            end
            default: begin
               ALUControl = ALU_ADD;
               RegW       = 1'b0;
               cmd_undef  = 1'b1;
            end
         endcase
         FlagW = {Funct[0], Funct[0] & is_arith};
      end
   end

   assign PCS = branch | ((Rd == 4'hF) & RegW);

`ifdef CU_ILLEGAL_DETECT_EN
   assign IllegalOp = (Op == OP_NONE) | cmd_undef;
`else
   logic unused_undef;
   assign unused_undef = cmd_undef;
`endif

   cond_logic u_cond_logic (
      .clk      (clk),
      .rst      (rst),
      .Cond     (Cond),
      .ALUFlags (ALUFlags),
      .FlagW    (FlagW),
      .PCS      (PCS),
      .RegW     (RegW),
      .MemW     (MemW),
      .PCSrc    (PCSrc),
      .RegWrite (RegWrite),
      .MemWrite (MemWrite)
   );

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed vectors push hand-computed control words,
// a monitor pops and compares them once the combinational outputs have settled.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] Op = 2'b11;
   logic [5:0] Funct = 6'd0;
   logic [3:0] Rd = 4'd0;
   logic [3:0] Cond = 4'hE;
   logic [3:0] ALUFlags = 4'd0;
   logic [1:0] FlagW;
   logic       PCS, RegW, MemW, MemtoReg, ALUSrc;
   logic [1:0] ImmSrc, RegSrc;
   logic [2:0] ALUControl;
   logic       PCSrc, RegWrite, MemWrite;
   logic       ill_act;

   control_unit dut (
      .clk        (clk),
      .rst        (rst),
      .Op         (Op),
      .Funct      (Funct),
      .Rd         (Rd),
      .Cond       (Cond),
      .ALUFlags   (ALUFlags),
      .FlagW      (FlagW),
      .PCS        (PCS),
      .RegW       (RegW),
      .MemW       (MemW),
      .MemtoReg   (MemtoReg),
      .ALUSrc     (ALUSrc),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .ALUControl (ALUControl),
      .PCSrc      (PCSrc),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite)
`ifdef CU_ILLEGAL_DETECT_EN
      ,
      .IllegalOp  (ill_act)
`endif
   );

`ifndef CU_ILLEGAL_DETECT_EN
   assign ill_act = 1'b0;
`endif

   always #5 clk = ~clk;

   logic [17:0] exp_q[$];
   string       name_q[$];
   int          req_cnt = 0;
   int          done_cnt = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   // Control word layout: {ill, FlagW, PCS, RegW, MemW, MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl, PCSrc, RegWrite, MemWrite}
   function automatic logic [17:0] cw(input logic [1:0] fw, input logic pcs, input logic rw,
                                      input logic mw, input logic m2r, input logic asrc,
                                      input logic [1:0] imm, input logic [1:0] rsrc,
                                      input logic [2:0] alu, input logic pcsrc,
                                      input logic rwr, input logic mwr, input logic ill);
      return {ill, fw, pcs, rw, mw, m2r, asrc, imm, rsrc, alu, pcsrc, rwr, mwr};
   endfunction

   task automatic apply(input string nm, input logic [1:0] op, input logic [5:0] fn,
                        input logic [3:0] rd, input logic [3:0] cnd, input logic [3:0] af,
                        input logic [17:0] expv);
      @(negedge clk);
      Op = op; Funct = fn; Rd = rd; Cond = cnd; ALUFlags = af;
      exp_q.push_back(expv);
      name_q.push_back(nm);
      req_cnt++;
      #2;
   endtask

   // Monitor: outputs are combinational, so each issued vector is "presented" 1 time unit later.
   initial begin
      logic [17:0] act, ev;
      string nm;
      forever begin
         wait (req_cnt > done_cnt);
         #1;
         act = {ill_act, FlagW, PCS, RegW, MemW, MemtoReg, ALUSrc, ImmSrc, RegSrc,
                ALUControl, PCSrc, RegWrite, MemWrite};
         ev = exp_q.pop_front();
         nm = name_q.pop_front();
`ifndef CU_ILLEGAL_DETECT_EN
         ev[17] = 1'b0;
`endif
         n_checks++;
         if (act !== ev) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", nm, act, ev);
         end
         done_cnt++;
      end
   end

   initial begin
      // Reset held: decode is live, flags are zero.
      apply("rst_op11", 2'b11, 6'b000000, 4'd0, 4'hE, 4'h0,
            cw(2'b00,0,0,0,0,0,2'b00,2'b00,3'b000,0,0,0,1));
      apply("rst_add_eq", 2'b00, 6'b001000, 4'd3, 4'h0, 4'h0,
            cw(2'b00,0,1,0,0,0,2'b00,2'b00,3'b000,0,0,0,0));
      rst = 1'b0;
      apply("add_reg_al", 2'b00, 6'b001000, 4'd3, 4'hE, 4'h0,
            cw(2'b00,0,1,0,0,0,2'b00,2'b00,3'b000,0,1,0,0));
      apply("subs_imm", 2'b00, 6'b100101, 4'd3, 4'hE, 4'b0100,
            cw(2'b11,0,1,0,0,1,2'b00,2'b00,3'b001,0,1,0,0));
      apply("eq_after_z", 2'b00, 6'b001000, 4'd3, 4'h0, 4'h0,
            cw(2'b00,0,1,0,0,0,2'b00,2'b00,3'b000,0,1,0,0));
      apply("ne_after_z", 2'b00, 6'b001000, 4'd3, 4'h1, 4'h0,
            cw(2'b00,0,1,0,0,0,2'b00,2'b00,3'b000,0,0,0,0));
      apply("ldr_pc", 2'b01, 6'b011001, 4'd15, 4'hE, 4'h0,
            cw(2'b00,1,1,0,1,1,2'b01,2'b00,3'b000,1,1,0,0));
      apply("str_al", 2'b01, 6'b011000, 4'd0, 4'hE, 4'h0,
            cw(2'b00,0,0,1,0,1,2'b01,2'b10,3'b000,0,0,1,0));
      apply("cmp_clr", 2'b00, 6'b010101, 4'd0, 4'hE, 4'h0,
            cw(2'b11,0,0,0,0,0,2'b00,2'b00,3'b001,0,0,0,0));
      apply("str_eq_z0", 2'b01, 6'b011000, 4'd0, 4'h0, 4'h0,
            cw(2'b00,0,0,1,0,1,2'b01,2'b10,3'b000,0,0,0,0));
      apply("b_al", 2'b10, 6'b100001, 4'd0, 4'hE, 4'h0,
            cw(2'b00,1,0,0,0,1,2'b10,2'b01,3'b000,1,0,0,0));
      apply("b_nv", 2'b10, 6'b100001, 4'd0, 4'hF, 4'h0,
            cw(2'b00,1,0,0,0,1,2'b10,2'b01,3'b000,0,0,0,0));
      apply("adds_cond_fail", 2'b00, 6'b001001, 4'd0, 4'h0, 4'hF,
            cw(2'b11,0,1,0,0,0,2'b00,2'b00,3'b000,0,0,0,0));
      apply("flags_kept", 2'b00, 6'b001000, 4'd0, 4'h0, 4'h0,
            cw(2'b00,0,1,0,0,0,2'b00,2'b00,3'b000,0,0,0,0));
      apply("movs_nz_only", 2'b00, 6'b011011, 4'd0, 4'hE, 4'hF,
            cw(2'b10,0,1,0,0,0,2'b00,2'b00,3'b101,0,1,0,0));
      apply("cs_after_movs", 2'b00, 6'b001000, 4'd0, 4'h2, 4'h0,
            cw(2'b00,0,1,0,0,0,2'b00,2'b00,3'b000,0,0,0,0));
      apply("mi_after_movs", 2'b00, 6'b001000, 4'd0, 4'h4, 4'h0,
            cw(2'b00,0,1,0,0,0,2'b00,2'b00,3'b000,0,1,0,0));
      apply("adds_all", 2'b00, 6'b001001, 4'd0, 4'hE, 4'hF,
            cw(2'b11,0,1,0,0,0,2'b00,2'b00,3'b000,0,1,0,0));
      apply("vs_set", 2'b00, 6'b001000, 4'd0, 4'h6, 4'h0,
            cw(2'b00,0,1,0,0,0,2'b00,2'b00,3'b000,0,1,0,0));
      apply("gt_z1", 2'b00, 6'b001000, 4'd0, 4'hC, 4'h0,
            cw(2'b00,0,1,0,0,0,2'b00,2'b00,3'b000,0,0,0,0));
      // Asynchronous reset between edges, with no clock edge before the next check.
      @(posedge clk);
      #2 rst = 1'b1;
      apply("async_rst_eq", 2'b00, 6'b001000, 4'd0, 4'h0, 4'h0,
            cw(2'b00,0,1,0,0,0,2'b00,2'b00,3'b000,0,0,0,0));
      apply("async_rst_ge", 2'b00, 6'b001000, 4'd0, 4'hA, 4'h0,
            cw(2'b00,0,1,0,0,0,2'b00,2'b00,3'b000,0,1,0,0));
      apply("op11_zero", 2'b11, 6'b111111, 4'd15, 4'hE, 4'hF,
            cw(2'b00,0,0,0,0,0,2'b00,2'b00,3'b000,0,0,0,1));
      rst = 1'b0;
      apply("undef_cmd", 2'b00, 6'b000110, 4'd0, 4'hE, 4'h0,
            cw(2'b00,0,0,0,0,0,2'b00,2'b00,3'b000,0,0,0,1));
      apply("and_reg", 2'b00, 6'b000000, 4'd0, 4'hE, 4'h0,
            cw(2'b00,0,1,0,0,0,2'b00,2'b00,3'b010,0,1,0,0));
      apply("orr_imm", 2'b00, 6'b111000, 4'd0, 4'hE, 4'h0,
            cw(2'b00,0,1,0,0,1,2'b00,2'b00,3'b011,0,1,0,0));
      apply("eor_reg", 2'b00, 6'b000010, 4'd0, 4'hE, 4'h0,
            cw(2'b00,0,1,0,0,0,2'b00,2'b00,3'b100,0,1,0,0));
      apply("add_rd15", 2'b00, 6'b001000, 4'd15, 4'hE, 4'h0,
            cw(2'b00,1,1,0,0,0,2'b00,2'b00,3'b000,1,1,0,0));
      apply("cmp_rd15", 2'b00, 6'b010100, 4'd15, 4'hE, 4'h0,
            cw(2'b00,0,0,0,0,0,2'b00,2'b00,3'b001,0,0,0,0));

      for (int i = 0; i < 20 && done_cnt < req_cnt; i++) #1;
      if (done_cnt < req_cnt) begin
         n_fail++;
         $display("FAIL monitor_drain: got %0d checked required %0d", done_cnt, req_cnt);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
